// File: rtl/seg7_scan_decoder_pkg.sv
// seg7_scan_decoder_pkg: glyph table, FSM encoding and one-hot helper shared by the scan decoder files
package seg7_scan_decoder_pkg;
  localparam logic [9:0][6:0] GLYPHS = {7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;
  function automatic logic one_hot4(input logic [3:0] a);
    return a != 4'd0 && (a & (a - 4'd1)) == 4'd0;
  endfunction
endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: scanned display inputs and captured-frame handshake
interface seg7_scan_decoder_if;
  logic [6:0] seg;
  logic [3:0] an;
  logic ready;
  logic [15:0] bcd;
  logic [3:0] err;
  logic valid;
  modport master(output seg, an, ready, input bcd, err, valid);
  modport slave(input seg, an, ready, output bcd, err, valid);
endinterface

// File: rtl/seg7_scan_decoder_seg7_to_bcd.sv
// seg7_to_bcd: combinational glyph lookup; unknown patterns give F with err set
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);
  always_comb begin
    bcd = 4'hF;
    err = 1'b1;
    for (int i = 0; i < 10; i++)
      if (seg == GLYPHS[i]) begin
        bcd = 4'(i);
        err = 1'b0;
      end
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: captures a stable multiplexed 4-digit 7-segment scan into a BCD frame with handshake
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic reset_n,
  seg7_scan_decoder_if.slave bus
);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  state_t state, state_nx;
  logic [6:0] last_seg;
  logic [3:0] last_an, count, count_nx, mask, mask_nx, dig, err_q;
  logic [15:0] bcd_q;
  logic dig_err, hot, match, capture;
  seg7_to_bcd u_dec (.seg(bus.seg), .bcd(dig), .err(dig_err));
  // a saturated run at STABLE keeps matching but must not recapture
  always_comb begin
    hot = one_hot4(bus.an);
    match = hot && bus.seg == last_seg && bus.an == last_an;
    count_nx = !hot ? 4'd0 : match ? (count == 4'd15 ? count : count + 4'd1) : 4'd1;
    capture = hot && count_nx == STABLE && !(match && count == STABLE);
    mask_nx = mask | (capture ? bus.an : 4'd0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= COLLECT;
    else state <= state_nx;
  always_comb
    state_nx = state == COLLECT ? (mask_nx == 4'hF ? HOLD : COLLECT) : (bus.ready ? COLLECT : HOLD);
  always_comb begin
    bus.valid = state == HOLD;
    bus.bcd = bcd_q;
    bus.err = err_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_seg <= 7'd0;
      last_an <= 4'd0;
      count <= 4'd0;
      mask <= 4'd0;
      bcd_q <= 16'd0;
      err_q <= 4'd0;
    end else if (state == COLLECT) begin
      last_seg <= bus.seg;
      last_an <= bus.an;
      count <= count_nx;
      mask <= mask_nx;
      for (int i = 0; i < 4; i++)
        if (capture && bus.an[i]) begin
          bcd_q[i*4+:4] <= dig;
          err_q[i] <= dig_err;
        end
    end else if (bus.ready) begin
      last_seg <= 7'd0;
      last_an <= 4'd0;
      count <= 4'd0;
      mask <= 4'd0;
    end
endmodule
